// File: rtl/cmd_aggregator.sv
// cmd_aggregator: assembles three UART bytes into a 24-bit command word held
// until the dispatcher clears it, and queues response bytes in a small FIFO
// that feeds the UART transmitter one byte per frame.
// Optional feature macro: CMD_TIMEOUT_EN enables an inter-byte timeout that
// discards a partial command after TIMEOUT_CYCLES idle cycles.
module cmd_aggregator #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_full,
    output logic        resp_ovf,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        RX_B0   = 2'd0,
        RX_B1   = 2'd1,
        RX_B2   = 2'd2,
        RX_HOLD = 2'd3
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    rx_state_t rx_state_q, rx_state_d;
    logic [23:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        accept;
    logic        to_expired;

    tx_state_t tx_state_q, tx_state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          mid_cmd;

    assign mid_cmd    = (rx_state_q == RX_B1) || (rx_state_q == RX_B2);
    assign to_expired = mid_cmd && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Inter-byte counter: runs only mid-command, restarts on every accepted byte.
    always_comb begin
        to_cnt_d = '0;
        if (mid_cmd && !accept && !to_expired) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_expired = 1'b0;
`endif

    assign accept     = rx_rdy && (rx_state_q != RX_HOLD);
    assign clr_rx_rdy = accept;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;

    // Receive FSM next state: byte capture into cmd, hold until the dispatcher clears.
    // An accepted byte takes priority over a timeout expiring in the same cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        case (rx_state_q)
            RX_B0: begin
                if (accept) begin
                    cmd_d      = {rx_data, cmd_q[15:0]};
                    rx_state_d = RX_B1;
                end
            end
            RX_B1: begin
                if (accept) begin
                    cmd_d      = {cmd_q[23:16], rx_data, cmd_q[7:0]};
                    rx_state_d = RX_B2;
                end else if (to_expired) begin
                    rx_state_d = RX_B0;
                end
            end
            RX_B2: begin
                if (accept) begin
                    cmd_d      = {cmd_q[23:8], rx_data};
                    rx_state_d = RX_HOLD;
                    cmd_rdy_d  = 1'b1;
                end else if (to_expired) begin
                    rx_state_d = RX_B0;
                end
            end
            RX_HOLD: begin
                if (clr_cmd_rdy) begin
                    rx_state_d = RX_B0;
                    cmd_rdy_d  = 1'b0;
                end
            end
            default: begin
                rx_state_d = RX_B0;
                cmd_rdy_d  = 1'b0;
            end
        endcase
    end

    // Receive FSM and command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_B0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (tx_state_q == TX_IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = send_resp && (!fifo_full || pop);

    assign resp_full  = fifo_full;
    assign resp_ovf   = ovf_q;
    assign trmt       = pop;
    assign tx_data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

    // Response FIFO and transmit FSM next state.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        tx_state_d = tx_state_q;

        if (push) begin
            mem_d[wr_ptr_q] = resp_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (send_resp && !push) begin
            ovf_d = 1'b1;
        end

        case (tx_state_q)
            TX_IDLE: if (pop)     tx_state_d = TX_BUSY;
            TX_BUSY: if (tx_done) tx_state_d = TX_IDLE;
            default:              tx_state_d = TX_IDLE;
        endcase
    end

    // Response FIFO storage, pointers, overflow flag and transmit FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_state_q <= tx_state_d;
        end
    end

endmodule

// File: tb/tb_cmd_aggregator.sv
// Self-checking bench for cmd_aggregator: command assembly, back-pressure,
// reset mid-command, response FIFO overflow and full push/pop ordering.
// With CMD_TIMEOUT_EN defined it also checks the inter-byte timeout.
module tb_cmd_aggregator;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_CYC = 16;
`else
    localparam int unsigned TO_CYC = 1000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = '0;
    logic        send_resp = 1'b0;
    logic        resp_full;
    logic        resp_ovf;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned clr_cnt = 0;
    int unsigned clr_base;
    logic        prev_cmd_rdy = 1'b0;

    logic [23:0] exp_cmd [$];
    logic [7:0]  exp_tx  [$];

    cmd_aggregator #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_data   (resp_data),
        .send_resp   (send_resp),
        .resp_full   (resp_full),
        .resp_ovf    (resp_ovf),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every transmit start is compared with the next expected byte.
    always @(negedge clk) begin
        if (rst_n && trmt) begin
            if (exp_tx.size() == 0) check("tx_unexpected", exp_tx.size(), 1);
            else check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
        end
    end

    // Scoreboard side: each new command is compared with the next expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cmd_rdy <= 1'b0;
        end else begin
            if (cmd_rdy && !prev_cmd_rdy) begin
                if (exp_cmd.size() == 0) check("cmd_unexpected", exp_cmd.size(), 1);
                else check("cmd_word", {8'h0, cmd}, {8'h0, exp_cmd.pop_front()});
            end
            if (clr_rx_rdy) clr_cnt++;
            prev_cmd_rdy <= cmd_rdy;
        end
    end

    // Called just after a posedge; returns just after the edge that captured the byte.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        while (!clr_rx_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_accept_wait", n, 0);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic pulse_clr_cmd();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    initial begin
        logic [7:0] burst [5];
        burst[0] = 8'hA5; burst[1] = 8'h11; burst[2] = 8'h22;
        burst[3] = 8'h33; burst[4] = 8'h44;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd", {8'h0, cmd}, 0);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_clr_rx_rdy", clr_rx_rdy, 0);
        check("rst_resp_full", resp_full, 0);
        check("rst_resp_ovf", resp_ovf, 0);
        check("rst_trmt", trmt, 0);
        check("rst_tx_data", tx_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Command assembly
        clr_base = clr_cnt;
        exp_cmd.push_back(24'h020905);
        send_byte(8'h02);
        send_byte(8'h09);
        send_byte(8'h05);
        @(negedge clk);
        check("asm_cmd_rdy", cmd_rdy, 1);
        check("asm_cmd", {8'h0, cmd}, 32'h020905);
        check("asm_clr_pulses", clr_cnt - clr_base, 3);

        // Back-pressure while a command is held
        @(posedge clk); #1;
        rx_data = 8'h08;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_no_clr", clr_rx_rdy, 0);
        end
        check("bp_cmd_frozen", {8'h0, cmd}, 32'h020905);
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        check("bp_no_accept_on_clear", clr_rx_rdy, 0);
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("bp_cmd_rdy_dropped", cmd_rdy, 0);
        check("bp_accept_next", clr_rx_rdy, 1);
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        @(negedge clk);
        check("bp_cmd_hi", {24'h0, cmd[23:16]}, 32'h08);
        exp_cmd.push_back(24'h080A0B);
        @(posedge clk); #1;
        send_byte(8'h0A);
        send_byte(8'h0B);
        @(negedge clk);
        check("bp_cmd_rdy", cmd_rdy, 1);
        @(posedge clk); #1;
        pulse_clr_cmd();

        // Clear strobe outside the hold state is ignored
        pulse_clr_cmd();
        @(negedge clk);
        check("ign_clr_cmd_rdy", cmd_rdy, 0);
        @(posedge clk); #1;

        // Reset mid-command discards the partial word
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        check("rstmid_cmd", {8'h0, cmd}, 0);
        check("rstmid_cmd_rdy", cmd_rdy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cmd.push_back(24'h334455);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        @(negedge clk);
        check("rstmid_fresh_cmd", {8'h0, cmd}, 32'h334455);
        @(posedge clk); #1;
        pulse_clr_cmd();

`ifdef CMD_TIMEOUT_EN
        // Inter-byte timeout drops a lone first byte
        send_byte(8'h77);
        repeat (TO_CYC) @(posedge clk);
        #1;
        exp_cmd.push_back(24'h0401FF);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'hFF);
        @(negedge clk);
        check("to_cmd_rdy", cmd_rdy, 1);
        check("to_cmd", {8'h0, cmd}, 32'h0401FF);
        @(posedge clk); #1;
        pulse_clr_cmd();
`endif

        // First response goes straight to the transmitter the next cycle
        exp_tx.push_back(8'hC3);
        resp_data = 8'hC3;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        @(negedge clk);
        check("tx_first_trmt", trmt, 1);
        @(negedge clk);
        check("tx_trmt_one_cycle", trmt, 0);
        @(posedge clk); #1;

        // Overflow: transmitter busy, five pushes into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            resp_data = burst[i];
            send_resp = 1'b1;
            if (i < 4) exp_tx.push_back(burst[i]);
            @(negedge clk);
            check("ovf_full_before_push", resp_full, (i == 4) ? 1 : 0);
            check("ovf_flag_before_push", resp_ovf, 0);
            @(posedge clk); #1;
        end
        send_resp = 1'b0;
        @(negedge clk);
        check("ovf_full", resp_full, 1);
        check("ovf_flag", resp_ovf, 1);
        check("ovf_busy_no_trmt", trmt, 0);
        @(posedge clk); #1;

        // Push and pop in the same cycle while full
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done   = 1'b0;
        resp_data = 8'h55;
        send_resp = 1'b1;
        exp_tx.push_back(8'h55);
        @(negedge clk);
        check("pp_trmt", trmt, 1);
        check("pp_full_before", resp_full, 1);
        @(posedge clk); #1;
        send_resp = 1'b0;
        @(negedge clk);
        check("pp_full_after", resp_full, 1);
        check("pp_ovf_sticky", resp_ovf, 1);
        @(posedge clk); #1;

        // Drain: each tx_done releases the next byte
        for (int i = 0; i < 4; i++) begin
            pulse_tx_done();
            @(posedge clk); #1;
        end
        pulse_tx_done();
        @(negedge clk);
        check("drain_full", resp_full, 0);
        check("drain_tx_data", tx_data, 0);
        check("drain_trmt", trmt, 0);
        check("drain_ovf_sticky", resp_ovf, 1);
        check("tx_leftover", exp_tx.size(), 0);
        check("cmd_leftover", exp_cmd.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
